// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS generator/checker pair: state encoding,
// default feedback masks and counter sizing.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;

    localparam logic [2:0] TAPS_3 = 3'b101;
    localparam logic [3:0] TAPS_4 = 4'b1001;
    localparam logic [6:0] TAPS_7 = 7'b1000001;

    localparam int ERR_CNT_WIDTH_DEF = 16;
    localparam int BIT_CNT_WIDTH     = 32;

    // Bits needed to hold 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lfsr_predict.sv
// Combinational Fibonacci LFSR step: predicted output bit and the register
// value after shifting that bit in. Used by both generator and checker.
module lfsr_predict
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = 3
) (
    input  logic [NUM_BITS-1:0] state_i,
    input  logic [NUM_BITS-1:0] taps_i,
    output logic                pred_o,
    output logic [NUM_BITS-1:0] next_o
);

    assign pred_o = ^(state_i & taps_i);
    assign next_o = {state_i[NUM_BITS-2:0], pred_o};

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS receive checker: FILL -> VERIFY -> LOCKED.
// Optional LFSR_CHK_BIT_COUNT_EN adds a saturating locked-bit counter o_Bit_Count.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int                  NUM_BITS      = 3,
    parameter logic [NUM_BITS-1:0] TAPS          = NUM_BITS'(TAPS_3),
    parameter int                  LOCK_COUNT    = 8,
    parameter int                  LOSS_COUNT    = 4,
    parameter int                  ERR_CNT_WIDTH = ERR_CNT_WIDTH_DEF
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic                     i_Enable,
    input  logic                     i_Clear,
    input  logic                     i_Data_DV,
    input  logic                     i_Data_Bit,
    output logic                     o_Locked,
    output logic                     o_Error,
`ifdef LFSR_CHK_BIT_COUNT_EN
    output logic [ERR_CNT_WIDTH-1:0] o_Error_Count,
    output logic [BIT_CNT_WIDTH-1:0] o_Bit_Count
`else
    output logic [ERR_CNT_WIDTH-1:0] o_Error_Count
`endif
);

    localparam int FILL_W  = cnt_w(NUM_BITS);
    localparam int MATCH_W = cnt_w(LOCK_COUNT);
    localparam int LOSS_W  = cnt_w(LOSS_COUNT);
    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(NUM_BITS - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_COUNT - 1);

    chk_state_e                state_q, state_d;
    logic [NUM_BITS-1:0]       lfsr_q, lfsr_d;
    logic [FILL_W-1:0]         fill_q, fill_d;
    logic [MATCH_W-1:0]        match_q, match_d;
    logic [LOSS_W-1:0]         consec_q, consec_d;
    logic [ERR_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic                      error_q, error_d;
    logic                      locked_q, locked_d;

    logic                      pred;
    logic [NUM_BITS-1:0]       pred_next;
    logic [NUM_BITS-1:0]       shift_in;
    logic                      accept;
    logic                      mismatch;

    lfsr_predict #(.NUM_BITS(NUM_BITS)) u_predict (
        .state_i (lfsr_q),
        .taps_i  (TAPS),
        .pred_o  (pred),
        .next_o  (pred_next)
    );

    assign accept   = i_Enable & i_Data_DV;
    assign mismatch = i_Data_Bit ^ pred;
    assign shift_in = {lfsr_q[NUM_BITS-2:0], i_Data_Bit};

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        fill_d    = fill_q;
        match_d   = match_q;
        consec_d  = consec_q;
        err_cnt_d = err_cnt_q;
        // Error is a strict pulse: any cycle without a locked mismatch clears it.
        error_d   = 1'b0;

        if (accept) begin
            unique case (state_q)
                ST_FILL: begin
                    lfsr_d = shift_in;
                    if (fill_q == FILL_LAST) begin
                        state_d = ST_VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                ST_VERIFY: begin
                    lfsr_d = shift_in;
                    // An all-zero register predicts zeros forever, so it may never lock.
                    if ((lfsr_q == '0) || mismatch) begin
                        state_d = ST_FILL;
                        fill_d  = '0;
                    end else if (match_q == MATCH_LAST) begin
                        state_d  = ST_LOCKED;
                        consec_d = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // Free-run on the prediction so a line error cannot corrupt the register.
                    lfsr_d = pred_next;
                    if (mismatch) begin
                        error_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                        if (consec_q == LOSS_LAST) begin
                            state_d  = ST_FILL;
                            fill_d   = '0;
                            consec_d = '0;
                        end else begin
                            consec_d = consec_q + 1'b1;
                        end
                    end else begin
                        consec_d = '0;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    fill_d  = '0;
                end
            endcase
        end

        if (i_Enable && i_Clear) err_cnt_d = '0;

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_FILL;
            lfsr_q    <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            consec_q  <= '0;
            err_cnt_q <= '0;
            error_q   <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            consec_q  <= consec_d;
            err_cnt_q <= err_cnt_d;
            error_q   <= error_d;
            locked_q  <= locked_d;
        end
    end

    assign o_Locked      = locked_q;
    assign o_Error       = error_q;
    assign o_Error_Count = err_cnt_q;

`ifdef LFSR_CHK_BIT_COUNT_EN
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (accept && (state_q == ST_LOCKED) && (bit_cnt_q != '1))
            bit_cnt_d = bit_cnt_q + 1'b1;
        if (i_Enable && i_Clear) bit_cnt_d = '0;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) bit_cnt_q <= '0;
        else          bit_cnt_q <= bit_cnt_d;
    end

    assign o_Bit_Count = bit_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed sequence plus randomized traffic, checked
// against a phase/history model of the checker. Two instances (16- and 2-bit counts).
module tb_lfsr_checker;

    localparam int NB   = 3;
    localparam int LOCK = 8;
    localparam int LOSS = 4;
    localparam logic [NB-1:0] TP = 3'b101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, clr = 1'b0, dv = 1'b0, din = 1'b0;
    logic lk, er, lk2, er2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
`ifdef LFSR_CHK_BIT_COUNT_EN
    logic [31:0] bc, bc2;
`endif

    int compared   = 0;
    int mismatched = 0;

    bit pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int gpos = 0;

    // Reference model: phase 0=fill, 1=verify, 2=locked; hist holds the last NB bits
    // the checker's register absorbed, oldest first.
    int     m_phase, m_nfill, m_nmatch, m_bad;
    bit     m_err;
    longint m_errs, m_bits;
    bit     hist[$];

    always #5 clk = ~clk;

    lfsr_checker #(.NUM_BITS(NB), .TAPS(TP), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS),
                   .ERR_CNT_WIDTH(16)) u_dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Clear(clr),
        .i_Data_DV(dv), .i_Data_Bit(din), .o_Locked(lk), .o_Error(er),
`ifdef LFSR_CHK_BIT_COUNT_EN
        .o_Error_Count(cnt), .o_Bit_Count(bc)
`else
        .o_Error_Count(cnt)
`endif
    );

    lfsr_checker #(.NUM_BITS(NB), .TAPS(TP), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS),
                   .ERR_CNT_WIDTH(2)) u_w2 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Clear(clr),
        .i_Data_DV(dv), .i_Data_Bit(din), .o_Locked(lk2), .o_Error(er2),
`ifdef LFSR_CHK_BIT_COUNT_EN
        .o_Error_Count(cnt2), .o_Bit_Count(bc2)
`else
        .o_Error_Count(cnt2)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat(input longint v, input longint mx);
        return 64'((v > mx) ? mx : v);
    endfunction

    function automatic bit m_pred();
        bit p = 1'b0;
        for (int j = 0; j < NB; j++)
            if (TP[j]) p ^= hist[NB-1-j];
        return p;
    endfunction

    task automatic m_push(input bit b);
        hist.push_back(b);
        void'(hist.pop_front());
    endtask

    task automatic model_reset();
        m_phase = 0; m_nfill = 0; m_nmatch = 0; m_bad = 0;
        m_err = 1'b0; m_errs = 0; m_bits = 0;
        hist.delete();
        for (int i = 0; i < NB; i++) hist.push_back(1'b0);
    endtask

    task automatic model_edge(input bit e, input bit v, input bit b, input bit c);
        bit p, mis, zero;
        m_err = 1'b0;
        if (!e) return;
        if (v) begin
            p    = m_pred();
            mis  = (b != p);
            zero = 1'b1;
            foreach (hist[i]) if (hist[i]) zero = 1'b0;
            if (m_phase == 2) begin
                m_bits++;
                m_push(p);
                if (mis) begin
                    m_err = 1'b1;
                    m_errs++;
                    m_bad++;
                    if (m_bad == LOSS) begin m_phase = 0; m_nfill = 0; end
                end else begin
                    m_bad = 0;
                end
            end else if (m_phase == 1) begin
                m_push(b);
                if (zero || mis) begin
                    m_phase = 0; m_nfill = 0;
                end else begin
                    m_nmatch++;
                    if (m_nmatch == LOCK) begin m_phase = 2; m_bad = 0; end
                end
            end else begin
                m_push(b);
                m_nfill++;
                if (m_nfill == NB) begin m_phase = 1; m_nmatch = 0; end
            end
        end
        if (c) begin m_errs = 0; m_bits = 0; end
    endtask

    task automatic check_all();
        chk("locked",   64'(lk),   64'(m_phase == 2));
        chk("error",    64'(er),   64'(m_err));
        chk("count",    64'(cnt),  sat(m_errs, 65535));
        chk("locked_w2", 64'(lk2), 64'(m_phase == 2));
        chk("count_w2", 64'(cnt2), sat(m_errs, 3));
`ifdef LFSR_CHK_BIT_COUNT_EN
        chk("bitcnt",   64'(bc),   sat(m_bits, 64'hFFFF_FFFF));
`endif
    endtask

    task automatic cycle(input bit e, input bit v, input bit b, input bit c);
        en = e; dv = v; din = b; clr = c;
        @(posedge clk); #1;
        model_edge(e, v, b, c);
        check_all();
    endtask

    task automatic send(input bit inv, input bit c);
        cycle(1'b1, 1'b1, pat[gpos % 7] ^ inv, c);
        gpos++;
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_locked", 64'(lk), 64'd0);
        chk("rst_error",  64'(er), 64'd0);
        chk("rst_count",  64'(cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        gpos = 0;
    endtask

    task automatic isolated_errors(input int n);
        for (int k = 0; k < n; k++) begin
            send(1'b1, 1'b0);
            repeat ($urandom_range(2, 5)) send(1'b0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1;
        do_reset();

        // Clean stream locks after 3 fill + 8 verify bits.
        for (int i = 1; i <= 11; i++) begin
            send(1'b0, 1'b0);
            if (i == 10) chk("pre_lock", 64'(lk), 64'd0);
            if (i == 11) chk("lock_at_11", 64'(lk), 64'd1);
        end
        repeat (100) send(1'b0, 1'b0);
        chk("clean_count", 64'(cnt), 64'd0);

        // Single inverted bit: one pulse, lock held.
        send(1'b1, 1'b0);
        chk("single_err_pulse", 64'(er), 64'd1);
        send(1'b0, 1'b0);
        chk("single_err_clear", 64'(er), 64'd0);
        chk("single_err_cnt", 64'(cnt), 64'd1);
        repeat ($urandom_range(3, 9)) send(1'b0, 1'b0);

        // Four consecutive errors drop lock, 11 good bits relock.
        for (int k = 1; k <= 4; k++) begin
            send(1'b1, 1'b0);
            if (k == 3) chk("burst_still_locked", 64'(lk), 64'd1);
        end
        chk("burst_lost", 64'(lk), 64'd0);
        chk("burst_cnt", 64'(cnt), 64'd5);
        for (int i = 1; i <= 11; i++) begin
            send(1'b0, 1'b0);
            if (i == 10) chk("relock_pre", 64'(lk), 64'd0);
        end
        chk("relock", 64'(lk), 64'd1);

        // All-zero stream never locks.
        do_reset();
        repeat (50) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("zero_nolock", 64'(lk), 64'd0);
        chk("zero_count", 64'(cnt), 64'd0);

        // DV gaps: lock point counted in accepted bits only.
        do_reset();
        for (int a = 1; a <= 11; a++) begin
            repeat ($urandom_range(0, 2)) cycle(1'b1, 1'b0, 1'($urandom), 1'b0);
            send(1'b0, 1'b0);
            if (a == 10) chk("gap_pre_lock", 64'(lk), 64'd0);
        end
        chk("gap_lock", 64'(lk), 64'd1);
        repeat (5) cycle(1'b0, 1'b1, 1'($urandom), 1'($urandom));
        chk("disabled_hold", 64'(lk), 64'd1);
        repeat (20) send(1'b0, 1'b0);

        // Clear together with an error: count cleared, pulse still seen.
        isolated_errors(3);
        chk("pre_clear_cnt", 64'(cnt), 64'd3);
        send(1'b1, 1'b1);
        chk("clear_cnt", 64'(cnt), 64'd0);
        chk("clear_pulse", 64'(er), 64'd1);
        chk("clear_keeps_lock", 64'(lk), 64'd1);

        // Narrow counter saturates.
        isolated_errors(6);
        chk("sat_w2", 64'(cnt2), 64'd3);
        chk("cnt_w16", 64'(cnt), 64'd6);

        // Asynchronous reset mid-lock.
        do_reset();

        // Randomized traffic with gaps, disables, clears and error injection.
        for (int i = 0; i < 600; i++) begin
            bit e, v, c, inv;
            e   = ($urandom_range(0, 9) != 0);
            v   = ($urandom_range(0, 3) != 0);
            c   = ($urandom_range(0, 39) == 0);
            inv = (i % 150 > 130) ? 1'b1 : ($urandom_range(0, 14) == 0);
            cycle(e, v, pat[gpos % 7] ^ inv, c);
            if (e && v) gpos++;
        end
        repeat (40) cycle(1'b1, 1'b1, 1'($urandom), 1'b0);
        repeat (30) send(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side checker for the serial pseudo-random bit stream produced by the team's Fibonacci LFSR generator.
- Self-synchronises by seeding its own LFSR from the first NUM_BITS received bits, then verifies the lock.
- Once locked, free-runs and compares each received bit against its prediction; reports lock status, per-bit error pulses and a saturating error count.
- Used for link bring-up and BER measurement at the far end of a PRBS link.

Parameters:
NUM_BITS, 3, LFSR length in bits (>=2).
TAPS, 3'b101, feedback mask; predicted bit = XOR of (r_LFSR & TAPS); width NUM_BITS.
LOCK_COUNT, 8, consecutive matches needed in VERIFY before entering LOCKED (>=1).
LOSS_COUNT, 4, consecutive mismatches in LOCKED that drop lock (>=1).
ERR_CNT_WIDTH, 16, width of error counter.

Ports:
i_Clk  input  1  clock.
i_Rst_L  input  1  asynchronous active-low reset.
i_Enable  input  1  block enable; when low, all state and outputs hold and i_Data_DV is ignored.
i_Clear  input  1  synchronous clear of error counter (and bit counter when compiled in).
i_Data_DV  input  1  i_Data_Bit valid this cycle.
i_Data_Bit  input  1  received serial PRBS bit.
o_Locked  output  1  high while in LOCKED.
o_Error  output  1  one-cycle pulse: accepted bit mismatched while LOCKED.
o_Error_Count  output  ERR_CNT_WIDTH  saturating count of LOCKED mismatches.

Behaviour:
- Accepted bit: i_Enable=1 and i_Data_DV=1. Nothing advances on other cycles.
- Reset (async, any time including mid-lock):
  - state=FILL; r_LFSR=0; fill/match/consecutive-error counters=0.
  - o_Locked=0, o_Error=0, o_Error_Count=0.
- Shift rule: r_LFSR <= {r_LFSR[NUM_BITS-2:0], b}. Prediction p = ^(r_LFSR & TAPS), computed from the register before the shift.
- FILL:
  - Shift in the received bit; fill_cnt++.
  - On the NUM_BITS-th accepted bit, go to VERIFY with match_cnt=0.
- VERIFY:
  - Shift in the received bit (self-synchronising).
  - If r_LFSR==0 before the shift, or received != p: go to FILL, fill_cnt=0. The bit is still shifted in but not counted.
  - Otherwise match_cnt++; on reaching LOCK_COUNT, go to LOCKED with consec_err=0.
- LOCKED:
  - Shift in p, not the received bit, so a single line error produces exactly one error.
  - Mismatch: o_Error=1 next cycle; o_Error_Count+1, saturating at all-ones; consec_err++. When consec_err reaches LOSS_COUNT, go to FILL with fill_cnt=0.
  - Match: consec_err=0.
- Timing:
  - o_Locked and o_Error are registered: they reflect the accepted bit one cycle later.
  - o_Locked rises the cycle after the bit that completes VERIFY and falls the cycle after the LOSS_COUNT-th consecutive error.
  - o_Error is 0 in every cycle without a LOCKED mismatch.
- Errors are never counted in FILL or VERIFY.
- i_Clear plus a simultaneous error: clear wins, count=0. o_Error still pulses.
- i_Clear does not affect lock state.
- An all-zero stream never locks.

Optional Feature:
- Macro: LFSR_CHK_BIT_COUNT_EN.
- Defined: adds output o_Bit_Count (32 bits, reset 0). It increments, saturating, on every accepted bit while LOCKED and is cleared by i_Clear with the same precedence as the error counter. Used for BER = errors/bits.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package lfsr_pkg:
  - state enum {FILL, VERIFY, LOCKED};
  - default tap constants per length (3'b101, 4'b1001, 7'b1000001);
  - counter width constants.
- Sub-module lfsr_predict: combinational. Inputs: state vector and TAPS. Outputs: prediction bit and next state. Shared with the generator so both ends use one polynomial definition.

Test Plan:
- Defaults. Repeating stream 1,1,0,1,0,0,1 (generator seeded 001), one bit per cycle -> o_Locked rises the cycle after the 11th accepted bit (3 fill + 8 verify). o_Error stays 0 and o_Error_Count=0 over 100 further bits.
- Locked. Invert one bit -> exactly one o_Error pulse, o_Error_Count=1, o_Locked stays 1. Invert 4 consecutive bits -> count=5, o_Locked falls after the 4th, then relocks 11 good bits later.
- All-zero input for 50 bits -> o_Locked never asserts, o_Error_Count=0.
- Valid stream with i_Data_DV toggling 1/0, and i_Enable held low for 5 cycles mid-lock -> same lock point in accepted-bit terms. No state change while i_Enable=0.
- While locked with o_Error_Count=3: assert i_Clear in the same cycle as an erroneous bit -> count=0 and o_Error pulses. Assert i_Rst_L low mid-lock -> all outputs 0 immediately (asynchronous).
- With ERR_CNT_WIDTH=2: inject 6 isolated errors -> count saturates at 3. With LFSR_CHK_BIT_COUNT_EN defined -> o_Bit_Count equals the number of accepted bits while LOCKED.
